// File: rtl/fir_cb_sequencer.sv
// ============================================================================
//  fir_cb_sequencer : write/read-sweep sequencer for the FIR circular buffer
//  Optional build macro: CB_OVERRUN_EN (sticky dropped-sample flag)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fir_cb_sequencer #(
  parameter int ADDR_W = 11,
  parameter int NREADS = 2048,
  parameter int RD_LAT = 2,
  parameter int DATA_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              x_stb,
  input  logic [DATA_W-1:0] xin,
  output logic [DATA_W-1:0] cb_din,
  output logic              cb_wen,
  output logic [ADDR_W-1:0] cb_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              mac_last,
  output logic              busy,
  output logic              overrun
);

  localparam int              DRAIN_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W-1:0]  C_LAST_RD = ADDR_W'(NREADS - 1);
  localparam logic [DRAIN_W-1:0] C_LAST_DR = DRAIN_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0]  C_ONE     = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_rd_cnt;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic [RD_LAT-1:0]   r_en_sr;
  logic [RD_LAT-1:0]   r_first_sr;
  logic [RD_LAT-1:0]   r_last_sr;

  logic w_issue;
  logic w_issue_first;
  logic w_issue_last;

  assign w_issue       = (r_state == S_READ);
  assign w_issue_first = w_issue && (r_rd_cnt == '0);
  assign w_issue_last  = w_issue && (r_rd_cnt == C_LAST_RD);

  // MAC strobes are the read-issue tags delayed to match the RAM read latency.
  assign mac_en    = r_en_sr[RD_LAT-1];
  assign mac_first = r_first_sr[RD_LAT-1];
  assign mac_last  = r_last_sr[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_cnt    <= '0;
      r_drain_cnt <= '0;
      r_en_sr     <= '0;
      r_first_sr  <= '0;
      r_last_sr   <= '0;
      cb_din      <= '0;
      cb_wen      <= 1'b0;
      cb_addr     <= '0;
      coef_addr   <= '0;
      busy        <= 1'b0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_en_sr[i]    <= r_en_sr[i-1];
        r_first_sr[i] <= r_first_sr[i-1];
        r_last_sr[i]  <= r_last_sr[i-1];
      end
      r_en_sr[0]    <= w_issue;
      r_first_sr[0] <= w_issue_first;
      r_last_sr[0]  <= w_issue_last;

      case (r_state)
        S_IDLE: begin
          cb_wen  <= 1'b0;
          cb_addr <= r_wr_ptr;
          if (x_stb) begin
            r_state <= S_WRITE;
            busy    <= 1'b1;
            cb_din  <= xin;
            cb_wen  <= 1'b1;
          end
        end
        S_WRITE: begin
          // The word just written is the newest; the sweep starts there.
          r_state   <= S_READ;
          cb_wen    <= 1'b0;
          cb_addr   <= r_wr_ptr;
          coef_addr <= '0;
          r_rd_cnt  <= '0;
          r_wr_ptr  <= r_wr_ptr + C_ONE;
        end
        S_READ: begin
          if (r_rd_cnt == C_LAST_RD) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= '0;
            cb_addr     <= r_wr_ptr;
          end else begin
            r_rd_cnt  <= r_rd_cnt + C_ONE;
            cb_addr   <= cb_addr - C_ONE;
            coef_addr <= r_rd_cnt + C_ONE;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == C_LAST_DR) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CB_OVERRUN_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun <= 1'b0;
    end else if (x_stb && (r_state != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_cb_sequencer.sv
// ============================================================================
//  tb_fir_cb_sequencer : randomized check of two sequencer configurations
//  against an event-schedule reference model. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_cb_sequencer;

  localparam int AW   = 3;
  localparam int DW   = 18;
  localparam int MAXE = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb = 1'b0;
  logic [DW-1:0] xin = '0;

  logic [DW-1:0] d0_din, d1_din;
  logic          d0_wen, d1_wen, d0_en, d1_en, d0_first, d1_first;
  logic          d0_last, d1_last, d0_busy, d1_busy, d0_ovr, d1_ovr;
  logic [AW-1:0] d0_addr, d1_addr, d0_coef, d1_coef;

  always #5 clk = ~clk;

  fir_cb_sequencer #(.ADDR_W(AW), .NREADS(4), .RD_LAT(2), .DATA_W(DW)) u_dut0 (
    .clock(clk), .reset(rst_n), .x_stb(stb), .xin(xin),
    .cb_din(d0_din), .cb_wen(d0_wen), .cb_addr(d0_addr), .coef_addr(d0_coef),
    .mac_en(d0_en), .mac_first(d0_first), .mac_last(d0_last),
    .busy(d0_busy), .overrun(d0_ovr));

  fir_cb_sequencer #(.ADDR_W(AW), .NREADS(1), .RD_LAT(1), .DATA_W(DW)) u_dut1 (
    .clock(clk), .reset(rst_n), .x_stb(stb), .xin(xin),
    .cb_din(d1_din), .cb_wen(d1_wen), .cb_addr(d1_addr), .coef_addr(d1_coef),
    .mac_en(d1_en), .mac_first(d1_first), .mac_last(d1_last),
    .busy(d1_busy), .overrun(d1_ovr));

  int n_checks = 0;
  int n_fails  = 0;
  int e_idx    = 0;

  // Expected outputs per clock edge, per configuration.
  int m_wen[2][MAXE], m_busy[2][MAXE], m_en[2][MAXE], m_first[2][MAXE];
  int m_last[2][MAXE], m_addr[2][MAXE], m_acare[2][MAXE];
  int m_coef[2][MAXE], m_ccare[2][MAXE];
  int m_ptr[2], m_din[2], m_free[2], m_ovr[2];

  function automatic int nreads(input int d); return (d == 0) ? 4 : 1; endfunction
  function automatic int rdlat(input int d);  return (d == 0) ? 2 : 1; endfunction

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d, input int from);
    for (int k = from; k < MAXE; k++) begin
      m_wen[d][k] = 0; m_busy[d][k] = 0; m_en[d][k] = 0; m_first[d][k] = 0;
      m_last[d][k] = 0; m_addr[d][k] = 0; m_acare[d][k] = 0;
      m_coef[d][k] = 0; m_ccare[d][k] = 0;
    end
  endtask

  task automatic model_edge(input int d, input logic r, input logic s, input logic [DW-1:0] x);
    int n, l, base, e;
    n = nreads(d);
    l = rdlat(d);
    e = e_idx;
    if (!r) begin
      model_clear(d, e);
      m_ptr[d] = 0; m_din[d] = 0; m_ovr[d] = 0; m_free[d] = e + 1;
    end else if (s) begin
      if (e >= m_free[d]) begin
        base = m_ptr[d];
        m_ptr[d] = (m_ptr[d] + 1) % (1 << AW);
        m_din[d] = int'(x);
        m_free[d] = e + n + l + 2;
        m_wen[d][e] = 1; m_addr[d][e] = base; m_acare[d][e] = 1;
        for (int k = e; k <= e + n + l && k < MAXE; k++) m_busy[d][k] = 1;
        for (int k = 0; k < n; k++) begin
          if (e + 1 + k + l < MAXE) begin
            m_addr[d][e+1+k]  = (base - k + (1 << AW)) % (1 << AW);
            m_acare[d][e+1+k] = 1;
            m_coef[d][e+1+k]  = k;
            m_ccare[d][e+1+k] = 1;
            m_en[d][e+1+k+l]  = 1;
            if (k == 0)     m_first[d][e+1+k+l] = 1;
            if (k == n - 1) m_last[d][e+1+k+l]  = 1;
          end
        end
      end else begin
        m_ovr[d] = 1;
      end
    end
  endtask

  task automatic check_edge(input int d, input logic r);
    logic [31:0] o_wen, o_busy, o_en, o_first, o_last, o_din, o_ovr, o_addr, o_coef;
    int e;
    e = e_idx;
    if (d == 0) begin
      o_wen = 32'(d0_wen); o_busy = 32'(d0_busy); o_en = 32'(d0_en); o_first = 32'(d0_first);
      o_last = 32'(d0_last); o_din = 32'(d0_din); o_ovr = 32'(d0_ovr);
      o_addr = 32'(d0_addr); o_coef = 32'(d0_coef);
    end else begin
      o_wen = 32'(d1_wen); o_busy = 32'(d1_busy); o_en = 32'(d1_en); o_first = 32'(d1_first);
      o_last = 32'(d1_last); o_din = 32'(d1_din); o_ovr = 32'(d1_ovr);
      o_addr = 32'(d1_addr); o_coef = 32'(d1_coef);
    end
    check_value($sformatf("d%0d wen e%0d", d, e), o_wen, 32'(m_wen[d][e]));
    check_value($sformatf("d%0d busy e%0d", d, e), o_busy, 32'(m_busy[d][e]));
    check_value($sformatf("d%0d mac_en e%0d", d, e), o_en, 32'(m_en[d][e]));
    check_value($sformatf("d%0d mac_first e%0d", d, e), o_first, 32'(m_first[d][e]));
    check_value($sformatf("d%0d mac_last e%0d", d, e), o_last, 32'(m_last[d][e]));
    check_value($sformatf("d%0d din e%0d", d, e), o_din, 32'(m_din[d]));
`ifdef CB_OVERRUN_EN
    check_value($sformatf("d%0d overrun e%0d", d, e), o_ovr, 32'(m_ovr[d]));
`else
    check_value($sformatf("d%0d overrun e%0d", d, e), o_ovr, 32'd0);
`endif
    if (m_acare[d][e] != 0)
      check_value($sformatf("d%0d addr e%0d", d, e), o_addr, 32'(m_addr[d][e]));
    else if (m_busy[d][e] == 0)
      check_value($sformatf("d%0d idle addr e%0d", d, e), o_addr, 32'(m_ptr[d]));
    if (m_ccare[d][e] != 0)
      check_value($sformatf("d%0d coef e%0d", d, e), o_coef, 32'(m_coef[d][e]));
    else if (!r)
      check_value($sformatf("d%0d rst coef e%0d", d, e), o_coef, 32'd0);
  endtask

  task automatic step(input logic r, input logic s, input logic [DW-1:0] x);
    rst_n = r; stb = s; xin = x;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_edge(d, r, s, x);
    #1;
    for (int d = 0; d < 2; d++) check_edge(d, r);
    e_idx++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      model_clear(d, 0);
      m_ptr[d] = 0; m_din[d] = 0; m_free[d] = 0; m_ovr[d] = 0;
    end
    repeat (4) step(1'b0, 1'b0, '0);
    idle(2);
    // Nine samples at the minimum period: pointer wraps on the ninth.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, (i == 0) ? 18'h00123 : DW'($urandom));
      idle(7);
    end
    // Strobes three edges in and on the final drain edge are dropped.
    step(1'b1, 1'b1, DW'($urandom));
    idle(2);
    step(1'b1, 1'b1, DW'($urandom));
    idle(3);
    step(1'b1, 1'b1, DW'($urandom));
    idle(8);
    // Reset in the middle of a sweep, then a fresh sample lands at address 0.
    step(1'b1, 1'b1, DW'($urandom));
    idle(2);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, DW'($urandom));
    idle(8);
    for (int i = 0; i < 700; i++)
      step(($urandom % 150) != 0, ($urandom % 4) == 0, DW'($urandom));
    idle(10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
